// File: rtl/pmp_seq_checker.sv
// Sequential PMP checker: one shared pmp_entry comparator,
// walking entries in priority order one per clock.
package riscv;
  typedef logic [2:0] pmp_access_t;
  typedef logic [1:0] priv_lvl_t;
  localparam priv_lvl_t PRIV_M = 2'b11;
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    TOR   = 2'd1,
    NA4   = 2'd2,
    NAPOT = 2'd3
  } pmp_addr_mode_t;
  typedef struct packed {
    logic           locked;
    pmp_addr_mode_t addr_mode;
    pmp_access_t    access_type;
  } pmpcfg_t;
endpackage

module pmp_entry #(
  parameter int unsigned PLEN    = 56,
  parameter int unsigned PMP_LEN = 54
) (
  input  logic [PLEN-1:0]        addr_i,
  input  logic [PMP_LEN-1:0]     conf_addr_i,
  input  logic [PMP_LEN-1:0]     conf_addr_prev_i,
  input  riscv::pmp_addr_mode_t  conf_addr_mode_i,
  output logic                   match_o
);
  logic [PMP_LEN+1:0] ab;
  logic [PMP_LEN+1:0] lo;
  logic [PMP_LEN+1:0] hi;
  logic [PMP_LEN-1:0] wa;
  logic [PMP_LEN-1:0] m;

  always_comb begin
    ab = (PMP_LEN+2)'(addr_i);
    wa = ab[PMP_LEN+1:2];
    lo = {conf_addr_prev_i, 2'b00};
    hi = {conf_addr_i, 2'b00};
    // NAPOT: trailing ones plus the next bit form the don't-care mask
    m  = conf_addr_i ^ (conf_addr_i + PMP_LEN'(1));
    match_o = 1'b0;
    case (conf_addr_mode_i)
      riscv::TOR:   match_o = (ab >= lo) && (ab < hi);
      riscv::NA4:   match_o = (wa == conf_addr_i);
      riscv::NAPOT: match_o = ((wa & ~m) == (conf_addr_i & ~m));
      default:      match_o = 1'b0;
    endcase
  end
endmodule

module pmp_seq_checker #(
  parameter int unsigned PLEN       = 56,
  parameter int unsigned PMP_LEN    = 54,
  parameter int unsigned NR_ENTRIES = 16,
  localparam int unsigned IW        = $clog2(NR_ENTRIES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [PLEN-1:0]      req_addr_i,
  input  riscv::pmp_access_t   req_access_i,
  input  riscv::priv_lvl_t     req_priv_i,
  input  logic [PMP_LEN-1:0]   conf_addr_i [NR_ENTRIES],
  input  riscv::pmpcfg_t       conf_i [NR_ENTRIES],
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_allow_o,
  output logic                 rsp_hit_o,
  output logic [IW-1:0]        rsp_idx_o
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [IW-1:0] LAST = IW'(NR_ENTRIES - 1);

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [PLEN-1:0]    addr_q, addr_d;
  riscv::pmp_access_t acc_q, acc_d;
  riscv::priv_lvl_t   priv_q, priv_d;
  logic               allow_q, allow_d;
  logic               hit_q, hit_d;
  logic [IW-1:0]      ridx_q, ridx_d;

  riscv::pmpcfg_t     cur;
  logic [PMP_LEN-1:0] prev;
  logic               match;

  assign cur  = conf_i[idx_q];
  assign prev = (idx_q == '0) ? '0
              : conf_addr_i[idx_q - IW'(1)];

  pmp_entry #(
    .PLEN    (PLEN),
    .PMP_LEN (PMP_LEN)
  ) u_entry (
    .addr_i           (addr_q),
    .conf_addr_i      (conf_addr_i[idx_q]),
    .conf_addr_prev_i (prev),
    .conf_addr_mode_i (cur.addr_mode),
    .match_o          (match)
  );

  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_allow_o = allow_q;
  assign rsp_hit_o   = hit_q;
  assign rsp_idx_o   = ridx_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    priv_d  = priv_q;
    allow_d = allow_q;
    hit_d   = hit_q;
    ridx_d  = ridx_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          addr_d  = req_addr_i;
          acc_d   = req_access_i;
          priv_d  = req_priv_i;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (match) begin
          hit_d   = 1'b1;
          ridx_d  = idx_q;
          // M-mode bypasses unlocked entries
          allow_d = ((priv_q == riscv::PRIV_M) && !cur.locked)
                 || ((acc_q & ~cur.access_type) == 3'b000);
          state_d = RESP;
        end else if (idx_q == LAST) begin
          hit_d   = 1'b0;
          ridx_d  = '0;
          allow_d = (priv_q == riscv::PRIV_M);
          state_d = RESP;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      acc_q   <= '0;
      priv_q  <= '0;
      allow_q <= 1'b0;
      hit_q   <= 1'b0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      priv_q  <= priv_d;
      allow_q <= allow_d;
      hit_q   <= hit_d;
      ridx_q  <= ridx_d;
    end
  end
endmodule

// File: doc/pmp_seq_checker.md
# pmp_seq_checker

Iterative PMP permission checker that sits directly upstream of a single `pmp_entry` comparator. It accepts one access request at a time and walks the PMP entries in priority order, one entry per clock, driving the shared comparator with the current entry's address, previous address and mode. It resolves the first matching entry against the latched access type and privilege level, then returns an allow/deny response over a valid/ready handshake. It trades latency for area: one comparator instead of `NR_ENTRIES`.

## Interface
- `PLEN`, 56, physical address width.
- `PMP_LEN`, 54, width of each pmpaddr register.
- `NR_ENTRIES`, 16, number of PMP entries; legal range 2..64.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous and active-high. Single clock domain.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request ready; high only in IDLE.
- `req_addr_i`  in  PLEN  physical address to check.
- `req_access_i`  in  3  `riscv::pmp_access_t`: bit0 R, bit1 W, bit2 X; exactly one bit set.
- `req_priv_i`  in  2  `riscv::priv_lvl_t`; `2'b11` is M-mode.
- `conf_addr_i`  in  NR_ENTRIES x PMP_LEN  pmpaddr array.
- `conf_i`  in  NR_ENTRIES x `riscv::pmpcfg_t`  per-entry `locked`, `addr_mode`, `access_type` (RWX).
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response ready.
- `rsp_allow_o`  out  1  access permitted.
- `rsp_hit_o`  out  1  some entry matched.
- `rsp_idx_o`  out  $clog2(NR_ENTRIES)  index of the matching entry; 0 when there is no hit.

## Operation
- The FSM has three states: IDLE, SCAN, RESP.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i && req_ready_o`, latch addr, access and priv, set `idx`=0, and go to SCAN.
- SCAN:
  - Drive the internal `pmp_entry` with the latched addr, `conf_addr_i[idx]`, `conf_i[idx].addr_mode`, and `conf_addr_prev` = `conf_addr_i[idx-1]`. For idx 0, `conf_addr_prev` is all zeros.
  - If `match`: set hit=1, record idx, compute allow, and go to RESP.
  - Allow rule on a hit:
    - If priv==M and `locked`==0, allow=1.
    - Otherwise, allow = `(req_access & ~access_type)==0`.
  - If there is no match and idx==NR_ENTRIES-1: set hit=0, idx=0, allow=(priv==M), and go to RESP.
  - Otherwise idx increments by 1.
  - OFF entries never match. The lowest-indexed match wins.
- RESP:
  - `rsp_valid_o`=1, with `rsp_allow_o`, `rsp_hit_o` and `rsp_idx_o` stable.
  - On `rsp_ready_i`, go to IDLE.
- `conf_addr_i` and `conf_i` are read live each SCAN cycle and are not latched. The result is defined only if the config is stable from the accept until the response. Software updates the PMP only while the checker is idle.
- The idx counter is `$clog2(NR_ENTRIES)` bits wide. The end-of-scan compare uses NR_ENTRIES-1, so the counter never wraps.

## Timing
- Reset (`rst_i`=1 at a rising edge):
  - State goes to IDLE. `rsp_valid_o`, `rsp_allow_o`, `rsp_hit_o` and `rsp_idx_o` go to 0.
  - `req_ready_o` is forced to 0 while `rst_i` is high.
- Reset mid-SCAN or mid-RESP aborts the request; no response is produced.
- Latency: with the accept edge at cycle 0, a match at entry k gives `rsp_valid_o` high in cycle k+2.
  - Worst case (miss) is cycle NR_ENTRIES+1.
- `rsp_valid_o` stays asserted with stable payload until `rsp_ready_i`; there is no timeout.
- After the response handshake, `req_ready_o` rises in the next cycle. Requests are never overlapped, so minimum spacing is k+3 cycles.
- `req_ready_o` is low in SCAN and RESP. A `req_valid_i` held high during that time is accepted on the first IDLE cycle.
- `rsp_ready_i` high in the same cycle that RESP is entered has no effect before `rsp_valid_o` is observed high.

## Test plan
- Entry 0: NAPOT, pmpaddr=0x1FF (4 KiB at 0x0), access RW, not locked. Request addr 0x800, W, priv U → response in cycle 2 with hit=1, idx=0, allow=1. Same setup with X → allow=0.
- Entries 0-2 OFF; entry 3 TOR with prev=0x100 and addr=0x200 (range 0x400..0x7FF), access R. Request addr 0x7FC, R, priv S → response in cycle 5 with hit=1, idx=3, allow=1. Request addr 0x800 → miss.
- All entries OFF, NR_ENTRIES=16. Priv M, addr 0x1234 → response in cycle 17 with hit=0, allow=1. Priv U → allow=0.
- Entry 5 NA4 at 0x4000 (pmpaddr 0x1000), locked, access R. Priv M, W → hit=1, idx=5, allow=0. Entry 5 unlocked → allow=1.
- Overlapping entries 1 and 4 both covering 0x2000 with different RWX → idx=1 permissions apply.
- Hold `rsp_ready_i`=0 for 10 cycles → payload stable throughout. Assert `rst_i` in SCAN cycle 3 → no response, outputs 0, `req_ready_o`=1 the cycle after reset deasserts.
